// File: rtl/vga_pkg.sv
// Shared VGA timing constants, fetch FSM state type and scanline helper
// for the text row scheduler and its register file.
package vga_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_TOTAL     = 525;
    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int ROM_LATENCY = 1;

    localparam logic [6:0] ASCII_SPACE = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_e;

    // Scanline that follows y, wrapping at the end of the frame.
    function automatic logic [9:0] next_line(input logic [9:0] y);
        return (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/text_row_scheduler_if.sv
// Bundle of sync-counter inputs, character-write port, shared ROM port and
// pixel outputs. The scheduler uses the slave side.
interface text_row_if;

    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        char_we;
    logic [2:0]  char_waddr;
    logic [6:0]  char_wdata;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy;
    logic        pixel_on;
    logic [7:0]  rgb;
    logic [2:0]  dbg_raddr;
    logic [6:0]  dbg_rdata;

    modport slave (
        input  video_on, x, y, char_we, char_waddr, char_wdata, rom_data, dbg_raddr,
        output rom_addr, busy, pixel_on, rgb, dbg_rdata
    );

    modport master (
        output video_on, x, y, char_we, char_waddr, char_wdata, rom_data, dbg_raddr,
        input  rom_addr, busy, pixel_on, rgb, dbg_rdata
    );

endinterface

// File: rtl/text_char_regs.sv
// Character register file: one write port, two combinational read ports
// (fetch and debug). Every slot resets to a space.
module text_char_regs
    import vga_pkg::*;
#(
    parameter int NUM_CHARS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  logic [6:0] wdata_i,
    input  logic [2:0] fetch_raddr_i,
    output logic [6:0] fetch_rdata_o,
    input  logic [2:0] dbg_raddr_i,
    output logic [6:0] dbg_rdata_o
);

    logic [6:0] chars_q [NUM_CHARS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                chars_q[i] <= ASCII_SPACE;
            end
        end else if (we_i && (32'(waddr_i) < NUM_CHARS)) begin
            chars_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write value in a write cycle, so a fetch racing a
    // write to the same slot still gets the old code.
    assign fetch_rdata_o = (32'(fetch_raddr_i) < NUM_CHARS) ? chars_q[fetch_raddr_i] : ASCII_SPACE;
    assign dbg_rdata_o   = (32'(dbg_raddr_i) < NUM_CHARS) ? chars_q[dbg_raddr_i] : ASCII_SPACE;

endmodule

// File: rtl/text_row_scheduler.sv
// Shares one ascii_rom across a text field: fetches a glyph row into a row
// buffer during h-blank, then serialises it as registered pixel/colour output.
module text_row_scheduler
    import vga_pkg::*;
#(
    parameter int         NUM_CHARS = 7,
    parameter int         X_START   = 192,
    parameter int         Y_START   = 208,
    parameter logic [7:0] FG_COLOR  = 8'h0F,
    parameter logic [7:0] BG_COLOR  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    text_row_if.slave  bus
);

    localparam int         FIELD_W   = CHAR_W * NUM_CHARS;
    localparam logic [2:0] LAST_SLOT = 3'(NUM_CHARS - 1);

    fetch_state_e state_q, state_d;
    logic [2:0]   k_q, k_d;
    logic [3:0]   row_q, row_d;
    logic [10:0]  last_addr_q, last_addr_d;
    logic [9:0]   x_prev_q;
    logic [7:0]   rowbuf_q [NUM_CHARS];
    logic [7:0]   rowbuf_d [NUM_CHARS];
    logic         pixel_on_q, pixel_on_d;
    logic [7:0]   rgb_q, rgb_d;

    logic         start;
    logic [9:0]   ny;
    logic         ny_in_band;
    logic [6:0]   fetch_code;
    logic [10:0]  issue_addr;
    logic         cap_en;
    logic [2:0]   cap_idx;
    logic         clear_buf;
    logic         in_field;
    logic [9:0]   x_off;
    logic [2:0]   slot;
    logic         glyph_bit;

    text_char_regs #(
        .NUM_CHARS (NUM_CHARS)
    ) u_char_regs (
        .clk           (clk),
        .rst           (rst),
        .we_i          (bus.char_we),
        .waddr_i       (bus.char_waddr),
        .wdata_i       (bus.char_wdata),
        .fetch_raddr_i (k_q),
        .fetch_rdata_o (fetch_code),
        .dbg_raddr_i   (bus.dbg_raddr),
        .dbg_rdata_o   (bus.dbg_rdata)
    );

    // Trigger stage: first clock at the start of h-blank
    assign start      = (bus.x == 10'(H_ACTIVE)) && (x_prev_q != 10'(H_ACTIVE));
    assign ny         = next_line(bus.y);
    assign ny_in_band = (ny >= 10'(Y_START)) && (ny < 10'(Y_START + CHAR_H));
    assign issue_addr = {fetch_code, row_q};

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        last_addr_d = last_addr_q;
        cap_en      = 1'b0;
        cap_idx     = k_q - 3'(ROM_LATENCY);
        clear_buf   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ny_in_band) begin
                        state_d = ISSUE;
                        k_d     = 3'd0;
                        row_d   = 4'(ny - 10'(Y_START));
                    end else begin
                        clear_buf = 1'b1;
                    end
                end
            end
            ISSUE: begin
                last_addr_d = issue_addr;
                cap_en      = (k_q != 3'd0);
                k_d         = k_q + 3'd1;
                if (k_q == LAST_SLOT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = LAST_SLOT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture stage: ROM data lands one clock after its address
    always_comb begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            rowbuf_d[i] = clear_buf ? 8'h00 : rowbuf_q[i];
        end
        if (cap_en && (32'(cap_idx) < NUM_CHARS)) begin
            rowbuf_d[cap_idx] = bus.rom_data;
        end
    end

    assign bus.rom_addr = (state_q == ISSUE) ? issue_addr : last_addr_q;
    assign bus.busy     = (state_q != IDLE);

    // Pixel stage: one registered clock from x/y to pixel_on/rgb
    assign in_field  = (bus.y >= 10'(Y_START)) && (bus.y < 10'(Y_START + CHAR_H)) &&
                       (bus.x >= 10'(X_START)) && (bus.x < 10'(X_START + FIELD_W));
    assign x_off     = bus.x - 10'(X_START);
    assign slot      = 3'(x_off >> 3);
    assign glyph_bit = (32'(slot) < NUM_CHARS) ? rowbuf_q[slot][3'd7 - bus.x[2:0]] : 1'b0;

    always_comb begin
        pixel_on_d = bus.video_on & in_field & glyph_bit;
        rgb_d      = !bus.video_on ? 8'h00 : (pixel_on_d ? FG_COLOR : BG_COLOR);
    end

    assign bus.pixel_on = pixel_on_q;
    assign bus.rgb      = rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            row_q       <= 4'd0;
            last_addr_q <= 11'd0;
            x_prev_q    <= 10'd0;
            pixel_on_q  <= 1'b0;
            rgb_q       <= 8'h00;
            for (int i = 0; i < NUM_CHARS; i++) begin
                rowbuf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            last_addr_q <= last_addr_d;
            x_prev_q    <= bus.x;
            pixel_on_q  <= pixel_on_d;
            rgb_q       <= rgb_d;
            for (int i = 0; i < NUM_CHARS; i++) begin
                rowbuf_q[i] <= rowbuf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_text_row_scheduler.sv
// Scoreboard bench for text_row_scheduler: a glyph ROM model, a character and
// row model, randomized lines, and a monitor comparing fetches and pixels.
module tb_text_row_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_row_if bus ();

    text_row_scheduler #(
        .NUM_CHARS (7),
        .X_START   (192),
        .Y_START   (208),
        .FG_COLOR  (8'h0F),
        .BG_COLOR  (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [10:0] addr_q [$];
    logic [8:0]  pix_q  [$];
    logic        chk_req = 1'b0;
    logic        chk_due = 1'b0;
    logic [6:0]  m_chars [7];
    logic [7:0]  m_row   [7];

    function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
        if (c == 7'h20) return 8'h00;
        return 8'(({1'b0, c} * 8'd37) ^ ({4'd0, r} * 8'd19) ^ 8'hA5);
    endfunction

    always @(posedge clk) bus.rom_data <= glyph(bus.rom_addr[10:4], bus.rom_addr[3:0]);

    function automatic logic [8:0] exp_pix(input int xi, input int yi, input logic vo);
        logic b;
        logic p;
        b = 1'b0;
        if (yi >= 208 && yi < 224 && xi >= 192 && xi < 248)
            b = m_row[(xi - 192) / 8][7 - (xi % 8)];
        p = vo & b;
        return {p, (!vo ? 8'h00 : (p ? 8'h0F : 8'hFF))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) chk_due <= chk_req && !rst;

    always @(negedge clk) begin
        logic [10:0] ea;
        logic [8:0]  ep;
        if (!rst && bus.busy) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: busy with rom_addr %0h, none expected", bus.rom_addr);
            end else begin
                ea = addr_q.pop_front();
                check("fetch_rom_addr", 32'(bus.rom_addr), 32'(ea));
            end
        end
        if (chk_due) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_unexpected: got %0h, none expected", {bus.pixel_on, bus.rgb});
            end else begin
                ep = pix_q.pop_front();
                check("pixel_on", 32'(bus.pixel_on), 32'(ep[8]));
                check("rgb", 32'(bus.rgb), 32'(ep[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input int slot, input logic [6:0] code);
        tick();
        bus.char_we    = 1'b1;
        bus.char_waddr = 3'(slot);
        bus.char_wdata = code;
        if (slot < 7) m_chars[slot] = code;
        tick();
        bus.char_we = 1'b0;
    endtask

    task automatic write_random();
        for (int s = 0; s < 7; s++) write_char(s, 7'($urandom_range(33, 126)));
        write_char(7, 7'($urandom_range(33, 126)));
    endtask

    task automatic check_dbg();
        for (int s = 0; s < 7; s++) begin
            bus.dbg_raddr = 3'(s);
            #1;
            check("dbg_char", 32'(bus.dbg_rdata), 32'(m_chars[s]));
        end
    endtask

    task automatic scan(input int yv, input int x0, input int x1, input int vo_mode);
        for (int xv = x0; xv <= x1; xv++) begin
            logic vo;
            vo = (vo_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(vo_mode);
            tick();
            bus.x        = 10'(xv);
            bus.y        = 10'(yv);
            bus.video_on = vo;
            chk_req      = 1'b1;
            pix_q.push_back(exp_pix(xv, yv, vo));
        end
        tick();
        chk_req      = 1'b0;
        bus.video_on = 1'b0;
        tick();
        check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
    endtask

    task automatic fetch_line(input int yv, input int coll_slot, input logic [6:0] coll_code,
                              input int rst_at);
        logic [6:0] snap [7];
        int         ny;
        logic [3:0] r;
        tick();
        bus.video_on = 1'b0;
        bus.y        = 10'(yv);
        bus.x        = 10'd639;
        tick();
        bus.x = 10'd640;
        ny    = (yv == 524) ? 0 : yv + 1;
        r     = 4'(ny - 208);
        snap  = m_chars;
        if (ny >= 208 && ny < 224) begin
            if (rst_at < 0) begin
                for (int s = 0; s < 7; s++) begin
                    addr_q.push_back({snap[s], r});
                    m_row[s] = glyph(snap[s], r);
                end
                addr_q.push_back({snap[6], r});
            end else begin
                for (int s = 0; s < rst_at; s++) addr_q.push_back({snap[s], r});
            end
        end else begin
            for (int s = 0; s < 7; s++) m_row[s] = 8'h00;
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            bus.char_we = 1'b0;
            if (coll_slot >= 0 && i == coll_slot + 1) begin
                bus.char_we    = 1'b1;
                bus.char_waddr = 3'(coll_slot);
                bus.char_wdata = coll_code;
                m_chars[coll_slot] = coll_code;
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst   = 1'b1;
                bus.x = 10'd0;
                #1;
                check("midfetch_busy", 32'(bus.busy), 32'd0);
                check("midfetch_rom_addr", 32'(bus.rom_addr), 32'd0);
                check("midfetch_pixel_on", 32'(bus.pixel_on), 32'd0);
                check("midfetch_rgb", 32'(bus.rgb), 32'd0);
                for (int s = 0; s < 7; s++) begin
                    m_chars[s] = 7'h20;
                    m_row[s]   = 8'h00;
                end
            end
            if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
        end
        check("fetch_complete", 32'(addr_q.size()), 32'd0);
        bus.x = 10'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.video_on   = 1'b0;
        bus.x          = 10'd0;
        bus.y          = 10'd0;
        bus.char_we    = 1'b0;
        bus.char_waddr = 3'd0;
        bus.char_wdata = 7'd0;
        bus.dbg_raddr  = 3'd0;
        for (int s = 0; s < 7; s++) begin
            m_chars[s] = 7'h20;
            m_row[s]   = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pixel_on", 32'(bus.pixel_on), 32'd0);
        check("reset_rgb", 32'(bus.rgb), 32'd0);
        check_dbg();
        tick();
        rst = 1'b0;

        for (int yv = 207; yv <= 223; yv++) begin
            fetch_line(yv, -1, 7'h00, -1);
            if (yv < 223) scan(yv + 1, 188, 251, 1);
        end

        write_char(0, 7'h48); write_char(1, 7'h45); write_char(2, 7'h4C);
        write_char(3, 7'h4C); write_char(4, 7'h4F); write_char(5, 7'h21);
        write_char(6, 7'h21);
        check_dbg();
        fetch_line(207, -1, 7'h00, -1);
        scan(208, 188, 251, 1);

        for (int it = 0; it < 3; it++) begin
            write_random();
            check_dbg();
            fetch_line(209, -1, 7'h00, -1);
            scan(210, 188, 251, 1);
        end

        write_char(3, 7'h41);
        fetch_line(211, 3, 7'h5A, -1);
        scan(212, 188, 251, 1);
        check_dbg();
        fetch_line(212, -1, 7'h00, -1);
        scan(213, 188, 251, 1);

        fetch_line(300, -1, 7'h00, -1);
        scan(213, 188, 251, 1);
        fetch_line(209, -1, 7'h00, -1);
        fetch_line(524, -1, 7'h00, -1);
        scan(210, 188, 251, 1);

        fetch_line(209, -1, 7'h00, -1);
        scan(210, 188, 251, 0);
        scan(210, 188, 251, 2);

        write_random();
        fetch_line(213, -1, 7'h00, 4);
        scan(214, 188, 251, 1);
        check_dbg();
        write_random();
        fetch_line(213, -1, 7'h00, -1);
        scan(214, 188, 251, 1);

        for (int it = 0; it < 6; it++) begin
            int yv;
            yv = $urandom_range(204, 226);
            write_char($urandom_range(0, 6), 7'($urandom_range(33, 126)));
            fetch_line(yv, -1, 7'h00, -1);
            scan(yv + 1, 188, 251, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
